// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
// seg7_scan_driver
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Frames are loaded into a pending buffer and promoted to the displayed
// (active) buffer only on a frame boundary, so a scan never mixes two frames.
// Each digit slot starts with a short all-anodes-off window to hide ghosting
// while the cathodes switch over to the next digit.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode,
    output logic                    frame_tick,
    output logic                    update_pend
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           slot_cnt;
    logic [CW-1:0]           slot_next;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_next;
    logic                    slot_end;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] active_digits;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic [4*NUM_DIGITS-1:0] pend_digits;
    logic [NUM_DIGITS-1:0]   pend_dp;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    upper_clear;
    logic [3:0]              sel_nib;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   anode_next;

    // BCD to active-low {a..g,dp}; 0xA is the dp-only pattern, 0xB..0xF blank
    function automatic logic [7:0] decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'h03;
            4'h1:    seg = 8'h9F;
            4'h2:    seg = 8'h25;
            4'h3:    seg = 8'h0D;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h49;
            4'h6:    seg = 8'h41;
            4'h7:    seg = 8'h1F;
            4'h8:    seg = 8'h01;
            4'h9:    seg = 8'h09;
            4'hA:    seg = 8'hFE;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // Next slot position: counter wraps each slot, digit index wraps each frame
    always_comb begin
        slot_end  = (slot_cnt == LAST_CNT);
        frame_end = slot_end && (idx == LAST_IDX);
        slot_next = slot_end ? '0 : slot_cnt + CW'(1);
        idx_next  = idx;
        if (slot_end) begin
            idx_next = (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
    end

    // Slot counter and digit index registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else begin
            slot_cnt <= slot_next;
            idx      <= idx_next;
        end
    end

    // Double buffer: loads land in pending and are promoted on the frame
    // boundary; a load on the boundary itself goes straight to active
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_digits <= '1;
            active_dp     <= '0;
            pend_digits   <= '0;
            pend_dp       <= '0;
            update_pend   <= 1'b0;
        end else if (load && frame_end) begin
            active_digits <= digits;
            active_dp     <= dp_en;
            pend_digits   <= digits;
            pend_dp       <= dp_en;
            update_pend   <= 1'b0;
        end else if (frame_end) begin
            if (update_pend) begin
                active_digits <= pend_digits;
                active_dp     <= pend_dp;
            end
            update_pend <= 1'b0;
        end else if (load) begin
            pend_digits <= digits;
            pend_dp     <= dp_en;
            update_pend <= 1'b1;
        end
    end

    // Leading-zero map: a digit blanks when it and everything above it are
    // zero and no digit above it shows a dp; the rightmost digit never blanks
    always_comb begin
        lz_blank    = '0;
        upper_clear = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (i != 0) begin
                lz_blank[i] = upper_clear && (active_digits[4*i +: 4] == 4'h0);
            end
            upper_clear = upper_clear && (active_digits[4*i +: 4] == 4'h0) && !active_dp[i];
        end
    end

    // Segment pattern for the digit currently selected, with dp overlay
    always_comb begin
        sel_nib  = active_digits[4*idx +: 4];
        seg_next = decode(sel_nib);
        if (blank_lz && lz_blank[idx]) begin
            seg_next = 8'hFF;
        end
        if (active_dp[idx]) begin
            seg_next[0] = 1'b0;
        end
    end

    // Anode follows the slot position being entered so it lines up with the counter
    always_comb begin
        anode_next = '1;
        if (slot_next >= BLANK_END) begin
            anode_next[idx_next] = 1'b0;
        end
    end

    // Registered pin drivers and frame-wrap pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode      <= '1;
            cathode    <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            anode      <= anode_next;
            cathode    <= seg_next;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
// tb_seg7_scan_driver
// Directed bench for the 4-digit scan driver with an 8-cycle slot and a
// 2-cycle blank window (32-cycle frame). `cyc` counts rising edges since the
// last reset release, so slot = cyc % 8 and digit index = (cyc / 8) % 4.
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp_en;
    logic        blank_lz;
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic        frame_tick;
    logic        update_pend;

    int checks;
    int errors;
    int cyc;

    seg7_scan_driver #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(8),
        .BLANK_CYC  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digits     (digits),
        .dp_en      (dp_en),
        .blank_lz   (blank_lz),
        .anode      (anode),
        .cathode    (cathode),
        .frame_tick (frame_tick),
        .update_pend(update_pend)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: inputs are captured on the rising edge, outputs sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto_cycle(input int target);
        while (cyc < target) tick();
    endtask

    task automatic apply_stimulus(input logic ld, input logic [15:0] d, input logic [3:0] dp);
        load   = ld;
        digits = d;
        dp_en  = dp;
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s at cyc %0d: observed 0x%02h expected 0x%02h", tag, cyc, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        reset    = 1'b1;
        blank_lz = 1'b0;
        apply_stimulus(1'b0, 16'h0000, 4'h0);

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_output("rst_anode", {4'h0, anode}, 8'h0F);
        check_output("rst_cathode", cathode, 8'hFF);
        check_output("rst_frame_tick", {7'd0, frame_tick}, 8'h00);
        check_output("rst_update_pend", {7'd0, update_pend}, 8'h00);
        reset = 1'b0;
        cyc   = 0;

        // First slot: blank window then digit 0 enabled
        goto_cycle(1);
        check_output("slot0_blank", {4'h0, anode}, 8'h0F);
        goto_cycle(2);
        check_output("slot0_on_start", {4'h0, anode}, 8'h0E);
        check_output("slot0_blank_digit", cathode, 8'hFF);
        goto_cycle(7);
        check_output("slot0_on_end", {4'h0, anode}, 8'h0E);

        // Load 1234 mid-frame: held pending until the boundary
        apply_stimulus(1'b1, 16'h1234, 4'h0);
        tick();
        apply_stimulus(1'b0, 16'h0000, 4'h0);
        check_output("pend_set", {7'd0, update_pend}, 8'h01);
        goto_cycle(9);
        check_output("no_tearing", cathode, 8'hFF);
        goto_cycle(31);
        check_output("tick_before_wrap", {7'd0, frame_tick}, 8'h00);
        check_output("pend_held", {7'd0, update_pend}, 8'h01);
        goto_cycle(32);
        check_output("tick_wrap1", {7'd0, frame_tick}, 8'h01);
        check_output("pend_cleared", {7'd0, update_pend}, 8'h00);
        goto_cycle(33);
        check_output("tick_one_cycle", {7'd0, frame_tick}, 8'h00);
        check_output("d0_1234", cathode, 8'h99);
        check_output("d0_blank_win", {4'h0, anode}, 8'h0F);
        goto_cycle(34);
        check_output("d0_anode", {4'h0, anode}, 8'h0E);
        goto_cycle(41);
        check_output("d1_1234", cathode, 8'h0D);
        goto_cycle(49);
        check_output("d2_1234", cathode, 8'h25);
        goto_cycle(57);
        check_output("d3_1234", cathode, 8'h9F);
        goto_cycle(58);
        check_output("d3_anode", {4'h0, anode}, 8'h07);
        goto_cycle(63);
        check_output("tick_before_wrap2", {7'd0, frame_tick}, 8'h00);
        goto_cycle(64);
        check_output("tick_wrap2", {7'd0, frame_tick}, 8'h01);

        // Leading-zero suppression on 0050
        blank_lz = 1'b1;
        apply_stimulus(1'b1, 16'h0050, 4'h0);
        tick();
        apply_stimulus(1'b0, 16'h0000, 4'h0);
        check_output("pend_0050", {7'd0, update_pend}, 8'h01);
        goto_cycle(97);
        check_output("lz_d0", cathode, 8'h03);
        goto_cycle(105);
        check_output("lz_d1", cathode, 8'h49);
        goto_cycle(113);
        check_output("lz_d2", cathode, 8'hFF);
        goto_cycle(121);
        check_output("lz_d3", cathode, 8'hFF);
        blank_lz = 1'b0;
        tick();
        check_output("lz_live_off", cathode, 8'h03);

        // Leading-zero with dp on digit 2
        blank_lz = 1'b1;
        apply_stimulus(1'b1, 16'h0050, 4'b0100);
        tick();
        apply_stimulus(1'b0, 16'h0000, 4'h0);
        goto_cycle(129);
        check_output("lzdp_d0", cathode, 8'h03);
        goto_cycle(137);
        check_output("lzdp_d1", cathode, 8'h49);
        goto_cycle(145);
        check_output("lzdp_d2", cathode, 8'hFE);
        goto_cycle(153);
        check_output("lzdp_d3", cathode, 8'hFF);
        blank_lz = 1'b0;

        // Two loads in one frame: the last one wins
        goto_cycle(154);
        apply_stimulus(1'b1, 16'h1111, 4'h0);
        tick();
        apply_stimulus(1'b0, 16'h0000, 4'h0);
        goto_cycle(156);
        apply_stimulus(1'b1, 16'h2222, 4'h0);
        tick();
        apply_stimulus(1'b0, 16'h0000, 4'h0);
        check_output("pend_2222", {7'd0, update_pend}, 8'h01);
        for (int c = 161; c <= 191; c++) begin
            goto_cycle(c);
            check_output("last_load_wins", cathode, 8'h25);
        end

        // Load on the boundary cycle: shown in this frame, never pending
        apply_stimulus(1'b1, 16'h7ACC, 4'b0010);
        tick();
        apply_stimulus(1'b0, 16'h0000, 4'h0);
        check_output("bnd_tick", {7'd0, frame_tick}, 8'h01);
        check_output("bnd_no_pend", {7'd0, update_pend}, 8'h00);
        goto_cycle(193);
        check_output("nib_C", cathode, 8'hFF);
        check_output("bnd_no_pend2", {7'd0, update_pend}, 8'h00);
        goto_cycle(201);
        check_output("nib_C_dp", cathode, 8'hFE);
        goto_cycle(209);
        check_output("nib_A", cathode, 8'hFE);
        goto_cycle(217);
        check_output("nib_7", cathode, 8'h1F);

        // Async reset mid-slot with a frame pending
        apply_stimulus(1'b1, 16'h8888, 4'h0);
        tick();
        apply_stimulus(1'b0, 16'h0000, 4'h0);
        check_output("pend_8888", {7'd0, update_pend}, 8'h01);
        goto_cycle(221);
        check_output("pre_rst_anode", {4'h0, anode}, 8'h07);
        reset = 1'b1;
        #1;
        check_output("async_anode", {4'h0, anode}, 8'h0F);
        check_output("async_cathode", cathode, 8'hFF);
        check_output("async_pend", {7'd0, update_pend}, 8'h00);
        check_output("async_tick", {7'd0, frame_tick}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        goto_cycle(31);
        check_output("post_rst_pend", {7'd0, update_pend}, 8'h00);
        goto_cycle(33);
        check_output("post_rst_d0", cathode, 8'hFF);
        check_output("post_rst_blank", {4'h0, anode}, 8'h0F);
        goto_cycle(34);
        check_output("post_rst_anode", {4'h0, anode}, 8'h0E);
        goto_cycle(57);
        check_output("post_rst_d3", cathode, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
